// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one fulladder slice per clock, LSB first.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a, b, cin;
//        out_valid/out_ready with sum, cout; busy is high outside IDLE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;
  logic             in_xfer;

  fulladder u_fa (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign in_xfer = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rst_n gates in_ready so it drops the instant reset asserts.
  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    sum       = res;
    cout      = carry;
  end

  // Result bits enter at the MSB and move right, so after WIDTH
  // slices the first (LSB) slice has reached bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (in_xfer) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      res   <= {fa_sum, res[WIDTH-1:1]};
      carry <= fa_cout;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// fulladder: 1-bit full adder cell.
// Ports: x, y, cin inputs; sum, cout outputs.
module fulladder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder, WIDTH=8.
// Driver pushes expected {cout,sum}; negedge monitor pops on output transfer.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];
  bit rand_mode = 1'b0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Monitor: out_valid/out_ready are stable at negedge, so a high pair
  // here means the coming posedge is an output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none",
                 {cout, sum});
      end else begin
        chk("result", {23'd0, cout, sum}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  // Random back-pressure, changed just after posedge to avoid racing
  // the negedge monitor.
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic [8:0] texp,
                      input bit push);
    int n = 0;
    @(negedge clk);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    if (push) exp_q.push_back(texp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  logic [7:0] dv_a[8] = '{8'h35, 8'hFF, 8'hFF, 8'h00,
                          8'h80, 8'hAA, 8'h0F, 8'h12};
  logic [7:0] dv_b[8] = '{8'h4A, 8'h01, 8'hFF, 8'h00,
                          8'h80, 8'h55, 8'hF1, 8'h34};
  logic       dv_c[8] = '{1'b0, 1'b0, 1'b1, 1'b1,
                          1'b0, 1'b1, 1'b0, 1'b0};
  logic [8:0] dv_e[8] = '{9'h07F, 9'h100, 9'h1FF, 9'h001,
                          9'h100, 9'h100, 9'h100, 9'h046};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int n;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum_cout", {23'd0, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: out_valid exactly 8 edges after the transfer edge.
    send(dv_a[0], dv_b[0], dv_c[0], dv_e[0], 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("latency_edge%0d", k), {31'd0, out_valid},
          {31'd0, (k == 8)});
    end

    for (int i = 1; i < 8; i++) begin
      send(dv_a[i], dv_b[i], dv_c[i], dv_e[i], 1'b1);
      wait_valid();
    end

    // Back-pressure with a pending operand held on the inputs.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 9'h030, 1'b1);
    wait_valid();
    a = 8'h11;
    b = 8'h00;
    cin = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {23'd0, cout, sum}, 32'h030);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    exp_q.push_back(9'h011);
    @(posedge clk);
    #1;
    chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted", {31'd0, busy}, 32'd1);
    wait_valid();

    // Reset on the 3rd RUN cycle; that result must never appear.
    @(posedge clk);
    #1;
    send(8'h55, 8'h22, 1'b0, 9'h077, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    send(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    wait_valid();

    // Random operands with in_valid and out_ready stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc}, 1'b1);
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
